// File: rtl/digit_spi_host.sv
`default_nettype none
// ============================================================================
// digit_spi_host
//   SPI mode-0 master: streams one frame into the digit recognizer, then reads
//   back its result. Define DIGIT_SPI_HOST_COST_READ_EN for a second (cost) byte.
//   Revision: 1.0
// ============================================================================
module digit_spi_host #(
  parameter int SCK_DIV     = 4,
  parameter int PIXEL_BYTES = 98
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       SCK,
  output logic       SS,
  output logic       MOSI,
  input  logic       MISO,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] cost
);

  localparam int               CNT_W       = (PIXEL_BYTES < 1) ? 1 : $clog2(PIXEL_BYTES + 1);
  localparam logic [7:0]       C_DIV_LAST  = 8'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] C_LABEL_IDX = CNT_W'(PIXEL_BYTES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_LOAD     = 3'd2,
    S_SHIFT    = 3'd3,
    S_READ     = 3'd4,
    S_DESELECT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_div_cnt, r_tx, r_rx, r_result;
  logic [2:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_sck, r_ss, r_busy, r_done, r_rd_primed;
  logic             w_tc, w_shifting, w_rise, w_fall, w_byte_end, w_last_rd;

`ifdef DIGIT_SPI_HOST_COST_READ_EN
  logic       r_rd_idx;
  logic [7:0] r_cost;
  assign w_last_rd = r_rd_idx;
  assign cost      = r_cost;
`else
  assign w_last_rd = 1'b1;
  assign cost      = 8'h00;
`endif

  assign SCK    = r_sck;
  assign SS     = r_ss;
  assign MOSI   = r_tx[7];
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // READ reuses the shift engine once its internal 0x00 load cycle has passed
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    w_tc       = (r_div_cnt == C_DIV_LAST);
    w_shifting = (r_state == S_SHIFT) || ((r_state == S_READ) && r_rd_primed);
    w_rise     = w_shifting && w_tc && !r_sck;
    w_fall     = w_shifting && w_tc && r_sck;
    w_byte_end = w_fall && (r_bit_cnt == 3'd7);
    case (r_state)
      S_IDLE:     if (start) w_next = S_SELECT;
      S_SELECT:   if (w_tc) w_next = S_LOAD;
      S_LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid) w_next = S_SHIFT;
      end
      S_SHIFT:    if (w_byte_end) w_next = (r_byte_cnt == C_LABEL_IDX) ? S_READ : S_LOAD;
      S_READ:     if (w_byte_end && w_last_rd) w_next = S_DESELECT;
      S_DESELECT: if (w_tc) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_div_cnt   <= 8'd0;
      r_tx        <= 8'd0;
      r_rx        <= 8'd0;
      r_result    <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= '0;
      r_sck       <= 1'b0;
      r_ss        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_primed <= 1'b0;
`ifdef DIGIT_SPI_HOST_COST_READ_EN
      r_rd_idx    <= 1'b0;
      r_cost      <= 8'd0;
`endif
    end else begin
      // Outputs registered from the next state so they switch cleanly with it
      r_ss   <= (w_next == S_IDLE) || (w_next == S_DESELECT) || (w_next == S_DONE);
      r_busy <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done <= (w_next == S_DONE);

      if ((r_state == S_SELECT) || (r_state == S_DESELECT) || w_shifting)
        r_div_cnt <= w_tc ? 8'd0 : r_div_cnt + 8'd1;
      else
        r_div_cnt <= 8'd0;

      if (w_shifting && w_tc) r_sck <= ~r_sck;
      if (w_rise) r_rx <= {r_rx[6:0], MISO};
      if (w_fall && (r_bit_cnt != 3'd7)) begin
        r_tx      <= {r_tx[6:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_byte_cnt  <= '0;
            r_rd_primed <= 1'b0;
`ifdef DIGIT_SPI_HOST_COST_READ_EN
            r_rd_idx    <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            r_tx      <= byte_data;
            r_bit_cnt <= 3'd0;
          end
        end
        S_SHIFT: begin
          if (w_byte_end && (r_byte_cnt != C_LABEL_IDX))
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
        S_READ: begin
          if (!r_rd_primed) begin
            r_tx        <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_rd_primed <= 1'b1;
          end else if (w_byte_end) begin
`ifdef DIGIT_SPI_HOST_COST_READ_EN
            if (r_rd_idx) begin
              r_cost <= r_rx;
            end else begin
              r_result    <= r_rx;
              r_rd_idx    <= 1'b1;
              r_rd_primed <= 1'b0;
            end
`else
            r_result <= r_rx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_spi_host.sv
`default_nettype none
// tb_digit_spi_host: random frames checked against a bit-level SPI slave model
// (MOSI stream, MISO capture, phase lengths, latency, handshake rules).
module tb_digit_spi_host;

  localparam int D  = 3;
  localparam int PB = 2;
`ifdef DIGIT_SPI_HOST_COST_READ_EN
  localparam int N_RD = 2;
`else
  localparam int N_RD = 1;
`endif
  localparam int N_BYTES  = PB + 1 + N_RD;
  localparam int N_BITS   = 8 * N_BYTES;
  localparam int RD_BASE  = 8 * (PB + 1);
  localparam int BASE_LAT = D + N_BYTES * (16 * D + 1) + D + 1;

  logic       clk = 1'b0;
  logic       n_rst, start, byte_valid, MISO;
  logic [7:0] byte_data;
  logic       byte_ready, SCK, SS, MOSI, busy, done;
  logic [7:0] result, cost;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] frame_bytes [PB+1];
  logic [7:0] resp [2];
  logic       bits_mosi [N_BITS];
  logic       bits_miso [N_BITS];
  logic [7:0] last_result;

  always #5 clk = ~clk;

  digit_spi_host #(.SCK_DIV(D), .PIXEL_BYTES(PB)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .SCK(SCK), .SS(SS),
    .MOSI(MOSI), .MISO(MISO), .busy(busy), .done(done), .result(result),
    .cost(cost)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] pack(input int base, input bit from_miso);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++)
      v[7-i] = from_miso ? bits_miso[base+i] : bits_mosi[base+i];
    return v;
  endfunction

  task automatic rand_frame();
    for (int i = 0; i < PB; i++) frame_bytes[i] = 8'($urandom);
    frame_bytes[PB] = 8'($urandom_range(0, 9));
    resp[0] = 8'($urandom);
    resp[1] = 8'($urandom);
  endtask

  // One frame; noisy=1 toggles MISO every cycle so only rising-SCK samples matter
  task automatic run_frame(input int stall, input bit noisy, input bit poke);
    int cyc, acc, rises, lo_len, hi_len, stall_left, done_cyc, idle_bad;
    int phase_bad, ss_bad, rdy_bad, busy_bad, stall_bad;
    bit hs, expect_hs, stall_armed, got_done, prev_sck;
    logic [7:0] exp_res, exp_byte;
    cyc = 0; acc = 0; rises = 0; lo_len = 0; hi_len = 0; done_cyc = 0;
    phase_bad = 0; ss_bad = 0; rdy_bad = 0; busy_bad = 0; stall_bad = 0; idle_bad = 0;
    stall_left = stall; stall_armed = (stall > 0); expect_hs = 0; got_done = 0; prev_sck = 0;
    start = 1; byte_valid = 1; byte_data = frame_bytes[0]; MISO = 1'($urandom);
    while (!got_done && cyc < BASE_LAT + stall + 200) begin
      hs = byte_ready && byte_valid;
      step();
      cyc++;
      start = 0;
      if (expect_hs) begin
        check("stall_accept", hs, 1);
        expect_hs = 0;
      end
      if (hs) acc++;
      if (cyc == 1) check("busy_rise", busy, 1);
      if (cyc == 8) check("result_hold", result, last_result);
      if (SCK !== prev_sck) begin
        if (prev_sck) begin
          if (hi_len != D) phase_bad++;
        end else if ((rises % 8) != 0) begin
          if (lo_len != D) phase_bad++;
        end else if (lo_len < D + 1) phase_bad++;
        if (SCK) begin
          if (rises < N_BITS) begin
            bits_mosi[rises] = MOSI;
            bits_miso[rises] = MISO;
          end
          rises++;
        end
        lo_len = 0; hi_len = 0;
      end
      if (SCK) hi_len++; else lo_len++;
      prev_sck = SCK;
      if (SCK && SS) ss_bad++;
      if (byte_ready && (SCK || SS)) rdy_bad++;
      if (done ? busy : !busy) busy_bad++;
      if (done) begin
        got_done = 1; done_cyc = cyc; start = 1;
      end
      if (poke && cyc == 60) start = 1;
      if (stall_armed && acc == 1 && stall_left > 0) begin
        byte_valid = 0;
        if (byte_ready) begin
          stall_left--;
          if (SCK || SS) stall_bad++;
        end else if (stall_left < stall) stall_bad++;
      end else begin
        if (stall_armed && acc == 1) begin
          expect_hs = 1; stall_armed = 0;
        end
        if (acc <= PB) begin
          byte_valid = 1; byte_data = frame_bytes[acc];
        end else begin
          byte_valid = 0; byte_data = 8'($urandom);
        end
      end
      if (noisy || rises < RD_BASE || rises >= N_BITS) MISO = 1'($urandom);
      else MISO = resp[(rises - RD_BASE) / 8][7 - ((rises - RD_BASE) % 8)];
    end
    check("done_seen", got_done, 1);
    step();
    start = 0; byte_valid = 0;
    check("start_on_done_busy", busy, 0);
    check("idle_ss", SS, 1);
    check("idle_mosi", MOSI, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy || !SS || SCK || done) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);
    check("latency", done_cyc, BASE_LAT + stall);
    check("rise_count", rises, N_BITS);
    for (int b = 0; b < N_BYTES; b++) begin
      if (b <= PB) exp_byte = frame_bytes[b];
      else exp_byte = 8'h00;
      check($sformatf("mosi_byte%0d", b), pack(8 * b, 0), exp_byte);
    end
    exp_res = noisy ? pack(RD_BASE, 1) : resp[0];
    check("result", result, exp_res);
`ifdef DIGIT_SPI_HOST_COST_READ_EN
    check("cost", cost, noisy ? pack(RD_BASE + 8, 1) : resp[1]);
`else
    check("cost", cost, 0);
`endif
    check("sck_phase", phase_bad, 0);
    check("ss_during_sck", ss_bad, 0);
    check("ready_outside_load", rdy_bad, 0);
    check("busy_window", busy_bad, 0);
    check("stall_lines", stall_bad, 0);
    last_result = exp_res;
  endtask

  // Reset asserted while SCK is high on byte 1 bit 3
  task automatic reset_mid();
    int rises, cyc;
    bit prev;
    rises = 0; cyc = 0; prev = 0;
    start = 1; byte_valid = 1; byte_data = 8'($urandom);
    while (rises < 12 && cyc < 2000) begin
      step();
      cyc++;
      start = 0;
      byte_data = 8'($urandom);
      if (SCK && !prev) rises++;
      prev = SCK;
    end
    check("pre_rst_sck", SCK, 1);
    check("pre_rst_ss", SS, 0);
    n_rst = 1;
    #1;
    check("rst_ss", SS, 1);
    check("rst_sck", SCK, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    byte_valid = 0;
    @(negedge clk);
    n_rst = 0;
    step();
    last_result = 8'h00;
  endtask

  initial begin
    n_rst = 1; start = 0; byte_valid = 0; byte_data = 8'h00; MISO = 0; last_result = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ss", SS, 1);
    check("reset_sck", SCK, 0);
    check("reset_mosi", MOSI, 0);
    check("reset_ready", byte_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_cost", cost, 0);
    n_rst = 0;
    step();

    frame_bytes = '{8'hA5, 8'h3C, 8'h07};
    resp[0] = 8'h07; resp[1] = 8'h5A;
    run_frame(0, 0, 0);

    rand_frame();
    resp[0] = 8'h04; resp[1] = 8'h5A;
    run_frame(50, 0, 1);

    rand_frame();
    run_frame(0, 1, 0);

    reset_mid();

    for (int f = 0; f < 3; f++) begin
      rand_frame();
      run_frame((f == 1) ? 20 : 0, f == 2, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
